shift_counter_monitor: RTL and testbench
========================================

Name: shift_counter_monitor

Overview:
- Receiving end of the bouncing one-hot shift-counter pattern.
- Samples the WIDTH-bit one-hot pattern and decodes the lit bit position and sweep direction.
- Checks every step against the legal bounce sequence; counts bounces and protocol errors.
- Sits beside the shift counter as a checker / LED-position decoder; all outputs registered.

Parameters:
- WIDTH, 8, pattern width; WIDTH >= 3.
- CNT_W, 16, width of the bounce and error counters.
- IDX_W, $clog2(WIDTH), position index width (derived; not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  pattern is sampled on a rising edge of clk when high.
- pattern  input  WIDTH  observed counter value.
- clear_err  input  1  clears err_sticky and err_count.
- pos  output  IDX_W  index of the lit bit in the last accepted sample.
- dir  output  1  1 = moving toward MSB, 0 = toward LSB.
- locked  output  1  high while in TRACK.
- err_sticky  output  1  set on any tracking error; held until clear_err or reset.
- err_count  output  CNT_W  saturating count of tracking errors.
- bounce_count  output  CNT_W  saturating count of accepted samples at index 0 or WIDTH-1.

Behaviour:
- Reset (wins over all inputs): state SYNC, pos=0, dir=1, locked=0, err_sticky=0, err_count=0, bounce_count=0, anchor=0.
- No state or output changes when sample_en=0, except clear_err.
- One-hot check: exactly one bit set. idx = position of that bit.
- Outputs update on the same edge that samples pattern; they are visible one cycle after presentation.
- SYNC:
  - One-hot sample: anchor=idx, pos=idx, go to ACQ.
  - Otherwise stay in SYNC.
- ACQ:
  - One-hot sample with |idx-anchor|==1: dir=(idx>anchor), pos=idx, go to TRACK, locked=1. Counts as an accepted sample.
  - Other one-hot sample: becomes the new anchor; pos=idx; stay in ACQ.
  - Non-one-hot sample: go to SYNC.
  - No errors are counted in SYNC or ACQ.
- TRACK, expected next index:
  - dir=1 and pos<WIDTH-1: expect pos+1.
  - dir=1 and pos==WIDTH-1: expect WIDTH-2, dir becomes 0.
  - dir=0 and pos>0: expect pos-1.
  - dir=0 and pos==0: expect 1, dir becomes 1.
  - Direction flips on the step that leaves an end, matching the counter (MSB -> MSB-1).
- TRACK, match: pos=idx, dir updated as above. Counts as an accepted sample.
- TRACK, mismatch or non-one-hot sample:
  - err_sticky=1, err_count+1 (saturating), locked=0.
  - If the sample is one-hot: anchor=idx, pos=idx, go to ACQ. Otherwise go to SYNC.
- bounce_count: +1 on each accepted sample whose idx is 0 or WIDTH-1; saturates at all-ones.
- clear_err:
  - Same edge as an error: the error wins; err_sticky=1, err_count=1.
  - Otherwise both are cleared next edge.
  - No effect on tracking state.
- Stuck pattern (same one-hot value twice) in TRACK is an error.
- Reset mid-sweep: monitor re-acquires; two legal samples are needed before locked=1.

Decomposition:
- Package shift_counter_pkg:
  - monitor state enum {SYNC, ACQ, TRACK}.
  - Default WIDTH constant, shared with the shift counter.
  - Constant for the counter's reset pattern (LSB set).
- Sub-module onehot_decoder (combinational, parameter WIDTH): pattern -> valid, idx.
- FSM, expected-next logic and counters live in shift_counter_monitor.

Test Plan:
- Reset, then samples 0x01,0x02,0x04 -> after 2nd sample locked=1, dir=1; after 3rd pos=2, err_sticky=0.
- Full legal sweep 0x01 up to 0x80, back down to 0x01 (15 samples after lock) -> locked stays 1; dir=0 after 0x40 following 0x80; bounce_count=2 (0x80 and final 0x01); err_count=0.
- While locked at pos=3 dir=1, inject 0x20 -> err_sticky=1, err_count=1, locked=0, state ACQ. Then 0x40 -> locked=1, dir=1.
- Inject 0x00 and then 0x11 while locked -> first drops to SYNC with err_count+1. Second is non-one-hot in SYNC: no further count, pos unchanged.
- Error and clear_err on the same edge -> err_sticky=1, err_count=1. clear_err alone next cycle -> both 0, locked state unaffected.
- sample_en=0 for 5 cycles mid-sweep while pattern changes -> outputs frozen. Resume with the correct next value -> no error. Repeated value in TRACK -> error counted.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: types and constants shared by the bouncing shift counter and its monitor.
package shift_counter_pkg;

   typedef enum logic [1:0] {SYNC, ACQ, TRACK} mon_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // The counter comes out of reset with only the LSB lit.
   localparam logic [DEFAULT_WIDTH-1:0] RESET_PATTERN = DEFAULT_WIDTH'(1);

endpackage

// File: rtl/shift_counter_monitor_onehot_decoder.sv
// onehot_decoder: flags an exactly-one-hot pattern and returns the index of its lit bit.
module onehot_decoder
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int IDX_W = $clog2(WIDTH)
)(
   input  logic [WIDTH-1:0] pattern,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (pattern[i]) idx = IDX_W'(i);
   end

   assign valid = (pattern != '0) && ((pattern & (pattern - 1'b1)) == '0);

endmodule

// File: rtl/shift_counter_monitor.sv
// shift_counter_monitor: tracks a bouncing one-hot pattern, decodes position/direction,
// and counts bounces and protocol errors.
module shift_counter_monitor
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 16,
   localparam int IDX_W = $clog2(WIDTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] pattern,
   input  logic             clear_err,
   output logic [IDX_W-1:0] pos,
   output logic             dir,
   output logic             locked,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bounce_count
);

   localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);

   mon_state_t       state;
   logic [IDX_W-1:0] anchor, idx, exp_idx;
   logic             valid, adjacent, match, exp_dir, accepted, err_ev, at_end;

   onehot_decoder #(.WIDTH(WIDTH)) u_dec (
      .pattern (pattern),
      .valid   (valid),
      .idx     (idx)
   );

   // Direction flips on the step that leaves an end, as the counter does.
   always_comb begin
      exp_idx  = dir ? (pos == TOP ? TOP - 1'b1 : pos + 1'b1) : (pos == '0 ? IDX_W'(1) : pos - 1'b1);
      exp_dir  = dir ? (pos != TOP) : (pos == '0);
      adjacent = ({1'b0, idx} == {1'b0, anchor} + 1'b1) || ({1'b0, anchor} == {1'b0, idx} + 1'b1);
      match    = valid && (idx == exp_idx);
      accepted = sample_en && (state == ACQ ? valid && adjacent : state == TRACK && match);
      err_ev   = sample_en && state == TRACK && !match;
      at_end   = (idx == '0) || (idx == TOP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SYNC;
         pos          <= '0;
         dir          <= 1'b1;
         locked       <= 1'b0;
         anchor       <= '0;
         err_sticky   <= 1'b0;
         err_count    <= '0;
         bounce_count <= '0;
      end else begin
         if (sample_en) begin
            case (state)
               SYNC:
                  if (valid) begin
                     anchor <= idx;
                     pos    <= idx;
                     state  <= ACQ;
                  end
               ACQ:
                  if (!valid) begin
                     state <= SYNC;
                  end else if (adjacent) begin
                     dir    <= idx > anchor;
                     pos    <= idx;
                     state  <= TRACK;
                     locked <= 1'b1;
                  end else begin
                     anchor <= idx;
                     pos    <= idx;
                  end
               TRACK:
                  if (match) begin
                     pos <= idx;
                     dir <= exp_dir;
                  end else begin
                     locked <= 1'b0;
                     state  <= valid ? ACQ : SYNC;
                     if (valid) begin
                        anchor <= idx;
                        pos    <= idx;
                     end
                  end
               default: state <= SYNC;
            endcase
         end
         if (accepted && at_end && bounce_count != '1)
            bounce_count <= bounce_count + 1'b1;
         // An error on the same edge as clear_err wins and restarts the count at one.
         err_sticky <= err_ev | (err_sticky & ~clear_err);
         err_count  <= err_ev ? (clear_err ? CNT_W'(1) : err_count + CNT_W'(err_count != '1))
                              : (clear_err ? '0 : err_count);
      end
   end

endmodule

// File: tb/tb_shift_counter_monitor.sv
// tb_shift_counter_monitor: scenario tasks push expected outputs to a scoreboard and
// compare them against the monitor after each sampling edge.
module tb_shift_counter_monitor;
   import shift_counter_pkg::*;

   typedef struct packed {
      logic [2:0]  pos;
      logic        dir;
      logic        locked;
      logic        err_sticky;
      logic [15:0] err_count;
      logic [15:0] bounce_count;
   } obs_t;

   typedef struct packed {
      logic       en;
      logic       clr;
      logic [7:0] pat;
      obs_t       exp;
   } step_t;

   logic        clk = 1'b0, reset = 1'b1, sample_en = 1'b0, clear_err = 1'b0;
   logic [7:0]  pattern = '0;
   logic [2:0]  pos;
   logic        dir, locked, err_sticky;
   logic [15:0] err_count, bounce_count;

   obs_t sb[$];
   int   total = 0, bad = 0;

   always #5 clk = ~clk;

   shift_counter_monitor #(.WIDTH(8), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_en    (sample_en),
      .pattern      (pattern),
      .clear_err    (clear_err),
      .pos          (pos),
      .dir          (dir),
      .locked       (locked),
      .err_sticky   (err_sticky),
      .err_count    (err_count),
      .bounce_count (bounce_count)
   );

   function automatic step_t mk(logic en, logic clr, logic [7:0] pat, int p, logic d, logic l,
                                logic e, int ec, int bc);
      step_t s;
      s.en = en;
      s.clr = clr;
      s.pat = pat;
      s.exp.pos = 3'(p);
      s.exp.dir = d;
      s.exp.locked = l;
      s.exp.err_sticky = e;
      s.exp.err_count = 16'(ec);
      s.exp.bounce_count = 16'(bc);
      return s;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o = {pos, dir, locked, err_sticky, err_count, bounce_count};
      return o;
   endfunction

   task automatic drive(step_t s);
      sample_en = s.en;
      clear_err = s.clr;
      pattern   = s.pat;
      sb.push_back(s.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t s[$];
      obs_t got, exp;
      reset = 1'b1;
      s.push_back(mk(1, 1, 8'h08, 0, 1, 0, 0, 0, 0));
      s.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_lock();
      step_t s[$];
      obs_t got, exp;
      s.push_back(mk(1, 0, RESET_PATTERN, 0, 1, 0, 0, 0, 0));
      s.push_back(mk(1, 0, 8'h02, 1, 1, 1, 0, 0, 0));
      s.push_back(mk(1, 0, 8'h04, 2, 1, 1, 0, 0, 0));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL lock[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_sweep();
      step_t s[$];
      obs_t got, exp;
      for (int p = 3; p <= 7; p++) s.push_back(mk(1, 0, 8'(1 << p), p, 1, 1, 0, 0, p == 7 ? 1 : 0));
      for (int p = 6; p >= 0; p--) s.push_back(mk(1, 0, 8'(1 << p), p, 0, 1, 0, 0, p == 0 ? 2 : 1));
      for (int p = 1; p <= 3; p++) s.push_back(mk(1, 0, 8'(1 << p), p, 1, 1, 0, 0, 2));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL sweep[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_error();
      step_t s[$];
      obs_t got, exp;
      s.push_back(mk(1, 0, 8'h20, 5, 1, 0, 1, 1, 2));
      s.push_back(mk(1, 0, 8'h40, 6, 1, 1, 1, 1, 2));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL error[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_non_onehot();
      step_t s[$];
      obs_t got, exp;
      s.push_back(mk(1, 0, 8'h00, 6, 1, 0, 1, 2, 2));
      s.push_back(mk(1, 0, 8'h11, 6, 1, 0, 1, 2, 2));
      s.push_back(mk(1, 0, 8'h01, 0, 1, 0, 1, 2, 2));
      s.push_back(mk(1, 0, 8'h02, 1, 1, 1, 1, 2, 2));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL non_onehot[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_clear();
      step_t s[$];
      obs_t got, exp;
      s.push_back(mk(1, 1, 8'h10, 4, 1, 0, 1, 1, 2));
      s.push_back(mk(1, 0, 8'h20, 5, 1, 1, 1, 1, 2));
      s.push_back(mk(0, 1, 8'hff, 5, 1, 1, 0, 0, 2));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL clear[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_freeze_stuck();
      step_t s[$];
      obs_t got, exp;
      logic [7:0] junk[5] = '{8'h00, 8'hff, 8'h01, 8'h80, 8'h33};
      foreach (junk[k]) s.push_back(mk(0, 0, junk[k], 5, 1, 1, 0, 0, 2));
      s.push_back(mk(1, 0, 8'h40, 6, 1, 1, 0, 0, 2));
      s.push_back(mk(1, 0, 8'h80, 7, 1, 1, 0, 0, 3));
      s.push_back(mk(1, 0, 8'h80, 7, 1, 0, 1, 1, 3));
      s.push_back(mk(1, 0, 8'h40, 6, 0, 1, 1, 1, 3));
      foreach (s[i]) begin
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL freeze_stuck[%0d] got=%h expected=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_resync();
      step_t s[$];
      obs_t got, exp;
      s.push_back(mk(1, 0, 8'h20, 5, 0, 1, 1, 1, 3));
      s.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 0, 0));
      s.push_back(mk(1, 0, 8'h10, 4, 1, 0, 0, 0, 0));
      s.push_back(mk(1, 0, 8'h08, 3, 0, 1, 0, 0, 0));
      foreach (s[i]) begin
         reset = (i == 1);
         drive(s[i]);
         exp = sb.pop_front();
         got = observe();
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset_resync[%0d] got=%h expected=%h", i, got, exp);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_sweep();
      test_error();
      test_non_onehot();
      test_clear();
      test_freeze_stuck();
      test_reset_resync();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
